// File: rtl/cal_pkg.sv
// Calendar constants and the month-length helper shared by the counter and its bench.
package cal_pkg;

  localparam int DAY_W = 5;
  localparam int MON_W = 4;

  localparam logic [MON_W-1:0] JAN = 4'd1;
  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] MAR = 4'd3;
  localparam logic [MON_W-1:0] APR = 4'd4;
  localparam logic [MON_W-1:0] MAY = 4'd5;
  localparam logic [MON_W-1:0] JUN = 4'd6;
  localparam logic [MON_W-1:0] JUL = 4'd7;
  localparam logic [MON_W-1:0] AUG = 4'd8;
  localparam logic [MON_W-1:0] SEP = 4'd9;
  localparam logic [MON_W-1:0] OCT = 4'd10;
  localparam logic [MON_W-1:0] NOV = 4'd11;
  localparam logic [MON_W-1:0] DEC = 4'd12;

  localparam logic [DAY_W-1:0] DAYS_28 = 5'd28;
  localparam logic [DAY_W-1:0] DAYS_29 = 5'd29;
  localparam logic [DAY_W-1:0] DAYS_30 = 5'd30;
  localparam logic [DAY_W-1:0] DAYS_31 = 5'd31;

  // Days in a month; illegal month codes return 0 so any day check against them fails.
  function automatic logic [DAY_W-1:0] month_days(input logic [MON_W-1:0] month,
                                                  input logic leap);
    logic [DAY_W-1:0] len;
    len = '0;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: len = DAYS_31;
      APR, JUN, SEP, NOV:                len = DAYS_30;
      FEB:                               len = leap ? DAYS_29 : DAYS_28;
      default:                           len = '0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/month_len_lut.sv
// Combinational month/leap -> number of days lookup.
module month_len_lut
  import cal_pkg::*;
(
  input  logic [MON_W-1:0] month,
  input  logic             leap,
  output logic [DAY_W-1:0] len
);

  // Pure table lookup through the shared helper.
  always_comb begin
    len = month_days(month, leap);
  end

endmodule

// File: rtl/date_counter.sv
// Registered day/month counter advancing one day per tick, with validated
// synchronous load, sticky load-error flag and a Dec 31 -> Jan 1 wrap pulse.
module date_counter #(
  parameter int DAY_W   = cal_pkg::DAY_W,
  parameter int MON_W   = cal_pkg::MON_W,
  parameter int RST_DAY = 1,
  parameter int RST_MON = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [DAY_W-1:0] load_day,
  input  logic [MON_W-1:0] load_month,
  input  logic             leap,
  output logic [DAY_W-1:0] day,
  output logic [MON_W-1:0] month,
  output logic [DAY_W-1:0] month_len,
  output logic             wrap,
  output logic             err
);

  import cal_pkg::JAN;
  import cal_pkg::DEC;

  logic [DAY_W-1:0] day_q, day_d;
  logic [MON_W-1:0] month_q, month_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [DAY_W-1:0] cur_len;
  logic [DAY_W-1:0] load_len;
  logic             load_ok;

  // Length of the month currently held; also the month_len output.
  month_len_lut u_cur_len (
    .month (month_q),
    .leap  (leap),
    .len   (cur_len)
  );

  // Length of the month being loaded, used only to validate the load.
  month_len_lut u_load_len (
    .month (load_month),
    .leap  (leap),
    .len   (load_len)
  );

  // Load is legal only for a real month and a day inside that month.
  always_comb begin
    load_ok = (load_month >= JAN) && (load_month <= DEC) &&
              (load_day != '0) && (load_day <= load_len);
  end

  // Next-state: load beats tick; >= compare lets a stale Feb 29 roll to Mar 1.
  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    if (load) begin
      if (load_ok) begin
        day_d   = load_day;
        month_d = load_month;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end else if (tick) begin
      if (day_q >= cur_len) begin
        day_d = DAY_W'(1);
        if (month_q == DEC) begin
          month_d = JAN;
          wrap_d  = 1'b1;
        end else begin
          month_d = month_q + MON_W'(1);
        end
      end else begin
        day_d = day_q + DAY_W'(1);
      end
    end
  end

  // State registers; synchronous reset overrides load and tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      day_q   <= DAY_W'(RST_DAY);
      month_q <= MON_W'(RST_MON);
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign day       = day_q;
  assign month     = month_q;
  assign month_len = cur_len;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: reset, month/leap boundaries, loads, priority, full years.
module tb_date_counter;
  import cal_pkg::*;

  logic             clk;
  logic             rst;
  logic             tick;
  logic             load;
  logic [DAY_W-1:0] load_day;
  logic [MON_W-1:0] load_month;
  logic             leap;
  logic [DAY_W-1:0] day;
  logic [MON_W-1:0] month;
  logic [DAY_W-1:0] month_len;
  logic             wrap;
  logic             err;

  int checks = 0;
  int errors = 0;

  logic [MON_W+DAY_W-1:0] exp_q[$];

  date_counter dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .load_day   (load_day),
    .load_month (load_month),
    .leap       (leap),
    .day        (day),
    .month      (month),
    .month_len  (month_len),
    .wrap       (wrap),
    .err        (err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_load(input logic [DAY_W-1:0] d, input logic [MON_W-1:0] m);
    load_day   = d;
    load_month = m;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; load = 1'b0; load_day = '0; load_month = '0; leap = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({month, day} !== {4'd1, 5'd1}) begin
      errors++; $display("FAIL reset_date got %0d/%0d exp 1/1", month, day);
    end
    checks++;
    if ({wrap, err} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got wrap=%0b err=%0b exp 0 0", wrap, err);
    end
    checks++;
    if (month_len !== 5'd31) begin
      errors++; $display("FAIL reset_len got %0d exp 31", month_len);
    end
  endtask

  task automatic test_jan_count();
    int bad = 0;
    leap = 1'b0;
    for (int i = 2; i <= 31; i++) begin
      pulse_tick();
      if ({month, day} !== {4'd1, 5'(i)} || wrap !== 1'b0 || month_len !== 5'd31) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL jan_count got %0d bad steps exp 0", bad);
    end
    pulse_tick();
    checks++;
    if ({month, day} !== {4'd2, 5'd1}) begin
      errors++; $display("FAIL jan_to_feb got %0d/%0d exp 2/1", month, day);
    end
    checks++;
    if (month_len !== 5'd28 || wrap !== 1'b0) begin
      errors++; $display("FAIL feb_len got len=%0d wrap=%0b exp 28 0", month_len, wrap);
    end
  endtask

  task automatic test_feb();
    leap = 1'b0;
    do_load(5'd28, 4'd2);
    pulse_tick();
    checks++;
    if ({month, day} !== {4'd3, 5'd1}) begin
      errors++; $display("FAIL feb28_noleap got %0d/%0d exp 3/1", month, day);
    end
    leap = 1'b1;
    do_load(5'd28, 4'd2);
    pulse_tick();
    checks++;
    if ({month, day, month_len} !== {4'd2, 5'd29, 5'd29}) begin
      errors++; $display("FAIL feb28_leap got %0d/%0d len %0d exp 2/29 len 29", month, day, month_len);
    end
    pulse_tick();
    checks++;
    if ({month, day} !== {4'd3, 5'd1}) begin
      errors++; $display("FAIL feb29_leap got %0d/%0d exp 3/1", month, day);
    end
    leap = 1'b0;
  endtask

  task automatic test_dec_wrap();
    do_load(5'd31, 4'd12);
    checks++;
    if (wrap !== 1'b0) begin
      errors++; $display("FAIL load_no_wrap got %0b exp 0", wrap);
    end
    pulse_tick();
    checks++;
    if ({month, day, wrap} !== {4'd1, 5'd1, 1'b1}) begin
      errors++; $display("FAIL dec_wrap got %0d/%0d wrap %0b exp 1/1 wrap 1", month, day, wrap);
    end
    step();
    checks++;
    if ({month, day, wrap} !== {4'd1, 5'd1, 1'b0}) begin
      errors++; $display("FAIL wrap_one_cycle got %0d/%0d wrap %0b exp 1/1 wrap 0", month, day, wrap);
    end
  endtask

  task automatic test_invalid_load();
    logic [DAY_W-1:0] bd [4];
    logic [MON_W-1:0] bm [4];
    bd[0] = 5'd31; bm[0] = 4'd4;
    bd[1] = 5'd0;  bm[1] = 4'd5;
    bd[2] = 5'd1;  bm[2] = 4'd13;
    bd[3] = 5'd29; bm[3] = 4'd2;
    leap = 1'b0;
    do_load(5'd10, 4'd5);
    for (int i = 0; i < 4; i++) begin
      do_load(bd[i], bm[i]);
      checks++;
      if ({month, day, err} !== {4'd5, 5'd10, 1'b1}) begin
        errors++;
        $display("FAIL invalid_load_%0d got %0d/%0d err %0b exp 5/10 err 1", i, month, day, err);
      end
    end
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %0b exp 1", err);
    end
    do_load(5'd15, 4'd6);
    checks++;
    if ({month, day, err} !== {4'd6, 5'd15, 1'b0}) begin
      errors++; $display("FAIL valid_after_err got %0d/%0d err %0b exp 6/15 err 0", month, day, err);
    end
  endtask

  task automatic test_priority();
    tick = 1'b1;
    do_load(5'd4, 4'd7);
    tick = 1'b0;
    checks++;
    if ({month, day} !== {4'd7, 5'd4}) begin
      errors++; $display("FAIL load_beats_tick got %0d/%0d exp 7/4", month, day);
    end
    do_load(5'd0, 4'd7);
    rst = 1'b1;
    do_load(5'd8, 4'd8);
    rst = 1'b0;
    checks++;
    if ({month, day, err} !== {4'd1, 5'd1, 1'b0}) begin
      errors++; $display("FAIL rst_beats_load got %0d/%0d err %0b exp 1/1 err 0", month, day, err);
    end
    do_load(5'd31, 4'd12);
    rst = 1'b1;
    pulse_tick();
    rst = 1'b0;
    checks++;
    if ({month, day, wrap} !== {4'd1, 5'd1, 1'b0}) begin
      errors++; $display("FAIL rst_cancels_wrap got %0d/%0d wrap %0b exp 1/1 wrap 0", month, day, wrap);
    end
  endtask

  task automatic test_leap_drop();
    leap = 1'b1;
    do_load(5'd29, 4'd2);
    leap = 1'b0;
    #1;
    checks++;
    if ({month, day, month_len} !== {4'd2, 5'd29, 5'd28}) begin
      errors++; $display("FAIL leap_drop_len got %0d/%0d len %0d exp 2/29 len 28", month, day, month_len);
    end
    pulse_tick();
    checks++;
    if ({month, day} !== {4'd3, 5'd1}) begin
      errors++; $display("FAIL leap_drop_tick got %0d/%0d exp 3/1", month, day);
    end
  endtask

  // Full-year run: expected dates are queued from a calendar model and popped per tick.
  task automatic test_year(input logic leap_v, input int n);
    logic [DAY_W-1:0] md;
    logic [MON_W-1:0] mm;
    logic [MON_W+DAY_W-1:0] exp_v;
    int wraps = 0;
    int bad = 0;
    leap = leap_v;
    do_load(5'd1, 4'd1);
    md = 5'd1; mm = 4'd1;
    for (int i = 0; i < n; i++) begin
      if (md >= month_days(mm, leap_v)) begin
        md = 5'd1;
        mm = (mm == 4'd12) ? 4'd1 : mm + 4'd1;
      end else begin
        md = md + 5'd1;
      end
      exp_q.push_back({mm, md});
      pulse_tick();
      exp_v = exp_q.pop_front();
      if ({month, day} !== exp_v) bad++;
      if (wrap === 1'b1) wraps++;
      if (i == n - 2 && {month, day} !== {4'd12, 5'd31}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL year_leap%0b_track got %0d bad days exp 0", leap_v, bad);
    end
    checks++;
    if ({month, day} !== {4'd1, 5'd1}) begin
      errors++; $display("FAIL year_leap%0b_end got %0d/%0d exp 1/1", leap_v, month, day);
    end
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL year_leap%0b_wraps got %0d exp 1", leap_v, wraps);
    end
    leap = 1'b0;
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_jan_count();
    test_feb();
    test_dec_wrap();
    test_invalid_load();
    test_priority();
    test_leap_drop();
    test_year(1'b0, 365);
    test_year(1'b1, 366);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
- Registered calendar date generator: holds the current day-of-month and month, and advances one day per tick pulse.
- Sits directly upstream of the combinational today/tomorrow next-day stage.
- Its day output drives that stage's today input; its month-length output (30/31, plus February) replaces the single 30/31 select.
- Adds synchronous load of an arbitrary date and a year-rollover pulse.

Parameters:
- DAY_W, 5, width of day fields (values 1..31).
- MON_W, 4, width of month fields (values 1..12).
- RST_DAY, 1, day value after reset.
- RST_MON, 1, month value after reset.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  advance one day this cycle (single-cycle pulse; held high = advance every cycle).
- load  input  1  load load_day/load_month this cycle.
- load_day  input  DAY_W  day to load.
- load_month  input  MON_W  month to load.
- leap  input  1  current year is a leap year (February = 29 days).
- day  output  DAY_W  current day, registered.
- month  output  MON_W  current month, registered.
- month_len  output  DAY_W  days in current month, combinational from month and leap.
- wrap  output  1  one-cycle pulse, registered: Dec 31 -> Jan 1 rollover occurred.
- err  output  1  sticky flag: last load request was rejected.

Behaviour:
- Reset: only synchronous and active-high; it has priority over everything.
  - While rst=1 at a rising edge: day=RST_DAY, month=RST_MON, wrap=0, err=0.
- Month length: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; February 28, or 29 when leap=1. Illegal month values (0, 13..15) produce month_len=0; these are unreachable after reset.
- Priority per edge: rst > load > tick. If load and tick are high in the same cycle, load wins and the tick is dropped.
- Load validity: load_month in 1..12 AND load_day in 1..month_len(load_month, leap).
  - Valid load: day/month take the loaded values next cycle; err cleared to 0.
  - Invalid load (e.g. day 0, Apr 31, Feb 29 with leap=0, month 0/13): day/month unchanged; err set to 1. err stays 1 until the next valid load or reset.
- Tick, when day < month_len: day = day+1; month unchanged.
- Tick, when day >= month_len: day=1.
  - If month < 12: month = month+1.
  - If month == 12: month=1 and wrap=1 for exactly the following cycle.
- The >= compare is deliberate. If leap falls while sitting on Feb 29, the next tick goes to Mar 1, never Feb 30.
- wrap is 0 on every cycle other than the one after a December rollover. A load never asserts wrap.
- No tick and no load: all registers hold; wrap=0.
- Latency: day/month/wrap change one clock after the qualifying edge. month_len follows month and leap combinationally, with zero latency.
- Arithmetic: all day compares are unsigned at DAY_W bits. day+1 never overflows because day <= 31 is guaranteed by the load check.
- Reset mid-operation: asserting rst on any cycle, including alongside load or tick, yields the reset state next cycle. A pending wrap pulse is cancelled.

Decomposition:
- Shared package cal_pkg holds:
  - DAY_W and MON_W constants.
  - Month constants JAN..DEC.
  - Length constants DAYS_28/29/30/31.
  - Function month_days(month, leap) returning DAY_W bits; used by both the LUT and the bench model.
- One sub-module: month_len_lut (combinational month,leap -> length).
  - Instantiated twice: once for the current month, driving month_len; once for load_month, for load validation.
- date_counter contains the registers, priority logic and wrap/err generation.

Test Plan:
- Reset then 31 ticks with leap=0 -> day counts 1..31, then day=1 month=2; wrap stays 0; month_len reads 31 then 28.
- Load Feb 28, leap=0, one tick -> Mar 1. Load Feb 28, leap=1, one tick -> Feb 29; a second tick -> Mar 1.
- Load Dec 31, one tick -> day=1 month=1, wrap=1 for exactly one cycle, then 0.
- Invalid loads Apr 31, day 0 month 5, month 13, Feb 29 with leap=0 -> date unchanged and err=1 after each. A following valid load Jun 15 -> err=0, date Jun 15.
- load and tick in the same cycle with load Jul 4 -> Jul 4, not Jul 5. rst together with load Aug 8 -> Jan 1, err=0.
- Sit on Feb 29 (leap=1), drop leap to 0, then tick -> Mar 1. Run 365 ticks from Jan 1 with leap=0 -> back at Jan 1 with exactly one wrap pulse; with leap=1 this takes 366 ticks.
